modbus_req_tx: RTL and testbench

Request-side companion of the drive's Modbus RTU register link. The block polls a window of holding registers (default 310..319) on one slave. For each register it builds a 6-byte function-03 request, computes the Modbus CRC16 bit-serially, and presents the 64-bit frame with a one-cycle transmit strobe. It then waits for the response receiver's done strobe, or a timeout, before moving to the next register. It sits between the control logic and the UART framer/response decoder.

---
 rtl/modbus_req_tx.sv | 166 ++++++++++++++++
 tb/tb_modbus_req_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_req_tx.sv
// rtl/modbus_req_tx.sv - Modbus RTU holding-register poller with bit-serial CRC16; define MB_WRITE_EN for function-06 writes
module modbus_req_tx #(
    parameter logic [7:0]  SLAVE_ADDR  = 8'h01,
    parameter logic [15:0] REG_FIRST   = 16'd310,
    parameter logic [3:0]  REG_COUNT   = 4'd10,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned GAP_CYC     = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_done,
`ifdef MB_WRITE_EN
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
`endif
    output logic [47:0] Message,
    output logic [63:0] frame_out,
    output logic        tx_valid,
    output logic        busy,
    output logic [3:0]  cur_index,
    output logic        err_timeout
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CRC  = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    logic [2:0]  state;
    logic [15:0] crc;
    logic [5:0]  bit_cnt;
    logic [31:0] cnt;
    logic [15:0] poll_reg;
    logic [7:0]  crc_byte;
    logic [15:0] crc_mix;
    logic [15:0] crc_next;
    logic        launch;
    logic        is_write;
    logic [3:0]  index_next;

`ifdef MB_WRITE_EN
    logic        wr_op;
    logic [15:0] wr_addr_q;
    logic [15:0] wr_data_q;
`endif

    assign busy     = (state != S_IDLE);
    assign poll_reg = REG_FIRST + {12'h000, cur_index};

    // Next polled index, wrapping at the end of the register window
    assign index_next = (cur_index == REG_COUNT - 4'd1) ? 4'd0 : cur_index + 4'd1;

    // One CRC16 step: fold in the next message byte at its first bit, then shift once
    always_comb begin
        crc_byte = Message[{bit_cnt[5:3], 3'b000} +: 8];
        crc_mix  = (bit_cnt[2:0] == 3'd0) ? (crc ^ {8'h00, crc_byte}) : crc;
        crc_next = crc_mix[0] ? ((crc_mix >> 1) ^ 16'hA001) : (crc_mix >> 1);
    end

    // Whether a new transaction should be launched when one may begin
    always_comb begin
        launch   = start;
        is_write = 1'b0;
`ifdef MB_WRITE_EN
        launch   = start | wr_req;
        is_write = wr_op;
`endif
    end

    // Transaction sequencer: build, checksum, present, await response, idle gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            Message     <= '0;
            frame_out   <= '0;
            tx_valid    <= 1'b0;
            err_timeout <= 1'b0;
            cur_index   <= 4'd0;
            crc         <= 16'hFFFF;
            bit_cnt     <= 6'd0;
            cnt         <= 32'd0;
`ifdef MB_WRITE_EN
            wr_ack      <= 1'b0;
            wr_op       <= 1'b0;
            wr_addr_q   <= 16'h0000;
            wr_data_q   <= 16'h0000;
`endif
        end else begin
            tx_valid    <= 1'b0;
            err_timeout <= 1'b0;
`ifdef MB_WRITE_EN
            wr_ack      <= 1'b0;
            if ((state == S_IDLE) || ((state == S_GAP) && (cnt == GAP_CYC - 32'd1))) begin
                wr_op     <= wr_req;
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
`ifdef MB_WRITE_EN
                    if (wr_op) begin
                        Message <= {wr_data_q[7:0], wr_data_q[15:8], wr_addr_q[7:0], wr_addr_q[15:8], 8'h06, SLAVE_ADDR};
                    end else begin
                        Message <= {8'h01, 8'h00, poll_reg[7:0], poll_reg[15:8], 8'h03, SLAVE_ADDR};
                    end
`else
                    Message <= {8'h01, 8'h00, poll_reg[7:0], poll_reg[15:8], 8'h03, SLAVE_ADDR};
`endif
                    crc     <= 16'hFFFF;
                    bit_cnt <= 6'd0;
                    state   <= S_CRC;
                end
                S_CRC: begin
                    crc <= crc_next;
                    if (bit_cnt == 6'd47) begin
                        state <= S_SEND;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                S_SEND: begin
                    frame_out <= {crc[15:8], crc[7:0], Message};
                    tx_valid  <= 1'b1;
                    cnt       <= 32'd0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (rx_done || (cnt == TIMEOUT_CYC - 32'd1)) begin
                        err_timeout <= ~rx_done;
`ifdef MB_WRITE_EN
                        wr_ack      <= rx_done & wr_op;
`endif
                        if (!is_write) begin
                            cur_index <= index_next;
                        end
                        cnt   <= 32'd0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_CYC - 32'd1) begin
                        cnt   <= 32'd0;
                        state <= launch ? S_LOAD : S_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_req_tx.sv
// tb/tb_modbus_req_tx.sv - scoreboard bench for modbus_req_tx with a byte-level Modbus reference model
module tb_modbus_req_tx;

    localparam logic [7:0]  SA  = 8'h01;
    localparam logic [15:0] RF  = 16'd0;
    localparam logic [3:0]  RC  = 4'd10;
    localparam int          TO  = 100;
    localparam int          GAP = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_done = 1'b0;
    logic [47:0] Message;
    logic [63:0] frame_out;
    logic        tx_valid;
    logic        busy;
    logic [3:0]  cur_index;
    logic        err_timeout;
`ifdef MB_WRITE_EN
    logic        wr_req = 1'b0;
    logic [15:0] wr_addr = 16'h0000;
    logic [15:0] wr_data = 16'h0000;
    logic        wr_ack;
    int          ackq[$];
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          c;
        logic [63:0] f;
        logic [3:0]  idx;
    } tx_exp_t;

    tx_exp_t txq[$];
    int      toq[$];
    tx_exp_t mon_e;
    logic    tx_prev = 1'b0;
    logic    to_prev = 1'b0;

    int       t;
    logic [3:0] idx_m = 4'd0;

    modbus_req_tx #(
        .SLAVE_ADDR(SA), .REG_FIRST(RF), .REG_COUNT(RC),
        .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_done(rx_done),
`ifdef MB_WRITE_EN
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
`endif
        .Message(Message), .frame_out(frame_out), .tx_valid(tx_valid),
        .busy(busy), .cur_index(cur_index), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: wire bytes in order, Modbus CRC16 over bytes 0..5, CRC low byte sent first
    function automatic logic [63:0] exp_frame(input logic [7:0] func, input logic [15:0] reg_a,
                                              input logic [15:0] data);
        logic [7:0]  b [8];
        logic [15:0] c;
        logic [63:0] f;
        b[0] = SA;
        b[1] = func;
        b[2] = reg_a[15:8];
        b[3] = reg_a[7:0];
        b[4] = data[15:8];
        b[5] = data[7:0];
        c = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            c = c ^ {8'h00, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        b[6] = c[7:0];
        b[7] = c[15:8];
        f = '0;
        for (int i = 0; i < 8; i++) f[8*i +: 8] = b[i];
        return f;
    endfunction

    task automatic push_tx(input int c, input logic [63:0] f, input logic [3:0] i);
        tx_exp_t e;
        e.c = c;
        e.f = f;
        e.idx = i;
        txq.push_back(e);
    endtask

    task automatic push_poll(input int c);
        push_tx(c, exp_frame(8'h03, RF + {12'h000, idx_m}, 16'h0001), idx_m);
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_rx();
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // One polled transaction whose tx_valid is expected in cycle t; d = response delay
    task automatic txn(input int d, input bit drop);
        int last;
        if (drop) begin
            wait_cycle(t - 20);
            start = 1'b0;
        end
        wait_cycle(t);
        if (d < TO) begin
            wait_cycle(t + d);
            pulse_rx();
            last = t + d;
        end else begin
            last = t + TO - 1;
            toq.push_back(t + TO);
            if (d < TO + GAP) begin
                wait_cycle(t + d);
                pulse_rx();
            end
        end
        idx_m = (idx_m == RC - 4'd1) ? 4'd0 : idx_m + 4'd1;
        if (!drop) begin
            t = last + GAP + 51;
            push_poll(t);
            wait_cycle(t - 30);
            pulse_rx();
        end else begin
            wait_cycle(last + GAP);
            check("busy_last_gap", {63'd0, busy}, 64'd1);
            @(negedge clk);
            check("busy_idle_after_stop", {63'd0, busy}, 64'd0);
            wait_cycle(last + GAP + 80);
            check("busy_stays_idle", {63'd0, busy}, 64'd0);
        end
    endtask

    // Monitor: every DUT strobe pops its expectation from the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid) begin
                check("tx_valid_width", {63'd0, tx_prev}, 64'd0);
                if (txq.size() == 0) begin
                    check("tx_unexpected", {63'd0, tx_valid}, 64'd0);
                end else begin
                    mon_e = txq.pop_front();
                    check("tx_cycle", 64'(cyc), 64'(mon_e.c));
                    check("frame_out", frame_out, mon_e.f);
                    check("message", {16'h0000, Message}, {16'h0000, mon_e.f[47:0]});
                    check("cur_index", {60'd0, cur_index}, {60'd0, mon_e.idx});
                end
            end
            if (err_timeout) begin
                check("err_timeout_width", {63'd0, to_prev}, 64'd0);
                if (toq.size() == 0) begin
                    check("err_timeout_unexpected", {63'd0, err_timeout}, 64'd0);
                end else begin
                    check("err_timeout_cycle", 64'(cyc), 64'(toq.pop_front()));
                end
            end
`ifdef MB_WRITE_EN
            if (wr_ack) begin
                if (ackq.size() == 0) begin
                    check("wr_ack_unexpected", {63'd0, wr_ack}, 64'd0);
                end else begin
                    check("wr_ack_cycle", 64'(cyc), 64'(ackq.pop_front()));
                end
            end
`endif
        end
        tx_prev = tx_valid;
        to_prev = err_timeout;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_message", {16'h0000, Message}, 64'd0);
        check("rst_frame_out", frame_out, 64'd0);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cur_index", {60'd0, cur_index}, 64'd0);
        check("rst_err_timeout", {63'd0, err_timeout}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Continuous polling with a mix of delays, collisions and timeouts
        start = 1'b1;
        t = cyc + 51;
        push_poll(t);
        wait_cycle(t);
        check("known_frame_reg0", frame_out, 64'h0A84_0100_0000_0301);
        txn(30, 1'b0);
        txn(0, 1'b0);
        txn(TO - 1, 1'b0);
        txn(TO, 1'b0);
        txn(TO + 5, 1'b0);
        for (int n = 0; n < 9; n++) txn($urandom_range(0, TO + GAP - 1), 1'b0);
        txn($urandom_range(0, TO - 2), 1'b1);

        // Restart from idle, then reset in the middle of the CRC phase
        start = 1'b1;
        t = cyc + 51;
        push_poll(t);
        txn(10, 1'b0);
        wait_cycle(t - 25);
        rst_n = 1'b0;
        #1;
        check("async_rst_message", {16'h0000, Message}, 64'd0);
        check("async_rst_frame_out", frame_out, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_cur_index", {60'd0, cur_index}, 64'd0);
        check("async_rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("async_rst_err_timeout", {63'd0, err_timeout}, 64'd0);
        txq.delete();
        toq.delete();
        idx_m = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = cyc + 51;
        push_poll(t);
        txn(40, 1'b0);
        txn(TO + 2, 1'b1);

`ifdef MB_WRITE_EN
        // Single-register write issued from idle with start low
        wr_addr = 16'h0001;
        wr_data = 16'h0003;
        wr_req = 1'b1;
        t = cyc + 51;
        push_tx(t, 64'h0B98_0300_0100_0601, idx_m);
        @(negedge clk);
        wr_req = 1'b0;
        wait_cycle(t + 7);
        ackq.push_back(t + 8);
        pulse_rx();
        wait_cycle(t + 7 + GAP + 5);
        check("wr_busy_idle", {63'd0, busy}, 64'd0);
        check("wr_cur_index_held", {60'd0, cur_index}, {60'd0, idx_m});
        check("ackq_empty", 64'(ackq.size()), 64'd0);
`endif

        repeat (5) @(negedge clk);
        check("txq_empty", 64'(txq.size()), 64'd0);
        check("toq_empty", 64'(toq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
